// File: rtl/procyon_ram_pkg.sv
// procyon_ram_pkg
//  Shared types and helpers for the procyon multi-port RAM.
//  - ram_init_state_t : clear-sequence FSM state
//  - lane_count()     : write-enable lanes per entry
//  - idx_width()      : address width for a given depth (min 1 bit)
package procyon_ram_pkg;

   typedef enum logic {
      RAM_INIT  = 1'b0,
      RAM_READY = 1'b1
   } ram_init_state_t;

   function automatic int lane_count(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

   function automatic int idx_width(input int depth);
      return (depth == 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/procyon_ram_mp_wr_merge.sv
// procyon_ram_mp_wr_merge
//  Per-lane priority mux over NUM_WR writers. For every lane the
//  highest-indexed writer with hit && byte_en[lane] supplies the data.
//  Used for the per-entry write path and for the read bypass path.
// Ports
//  hit      in  [NUM_WR]                 writer targets this entry
//  byte_en  in  [NUM_WR][NUM_LANES]      per-writer lane mask
//  data     in  [NUM_WR][W]              per-writer data
//  merged   out [W]                      merged lane data ('0 where no hit)
//  lane_hit out [NUM_LANES]              lanes written by some writer
module procyon_ram_mp_wr_merge
   import procyon_ram_pkg::*;
#(
   parameter int NUM_WR     = 1,
   parameter int NUM_LANES  = 8,
   parameter int BYTE_WIDTH = 8
) (
   input  logic [NUM_WR-1:0]                             hit,
   input  logic [NUM_WR-1:0][NUM_LANES-1:0]              byte_en,
   input  logic [NUM_WR-1:0][NUM_LANES*BYTE_WIDTH-1:0]   data,
   output logic [NUM_LANES*BYTE_WIDTH-1:0]               merged,
   output logic [NUM_LANES-1:0]                          lane_hit
);

   // Ascending port order: a later (higher) port overwrites an earlier one.
   always_comb begin
      merged   = '0;
      lane_hit = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (hit[p] && byte_en[p][l]) begin
               merged[l*BYTE_WIDTH +: BYTE_WIDTH] = data[p][l*BYTE_WIDTH +: BYTE_WIDTH];
               lane_hit[l] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/procyon_ram_mp.sv
// procyon_ram_mp
//  Parametrised multi-port RAM: NR read ports, NW write ports with byte-lane
//  masks, asynchronous (latency 0) or registered (latency 1) reads. After
//  reset every entry is cleared by hardware, one entry per cycle.
//  Optional macro PROCYON_RAM_MP_BYPASS_EN: same-cycle write data is
//  forwarded to colliding reads (post-write merged value).
// Ports
//  clk, n_rst          clock, synchronous active-low reset
//  o_ram_init_done     high once the clear sequence has finished
//  i_ram_rd_en/addr    per read port request
//  o_ram_rd_valid/data per read port response ('0 data when not valid)
//  i_ram_wr_en/addr    per write port request
//  i_ram_wr_byte_en    per write port lane mask
//  i_ram_wr_data       per write port data
module procyon_ram_mp
   import procyon_ram_pkg::*;
#(
   parameter  int OPTN_DATA_WIDTH   = 64,
   parameter  int OPTN_BYTE_WIDTH   = 8,
   parameter  int OPTN_RAM_DEPTH    = 32,
   parameter  int OPTN_NUM_RD_PORTS = 2,
   parameter  int OPTN_NUM_WR_PORTS = 1,
   parameter  int OPTN_RD_LATENCY   = 0,
   localparam int RAM_IDX_WIDTH     = idx_width(OPTN_RAM_DEPTH),
   localparam int NUM_LANES         = lane_count(OPTN_DATA_WIDTH, OPTN_BYTE_WIDTH)
) (
   input  logic                                                 clk,
   input  logic                                                 n_rst,
   output logic                                                 o_ram_init_done,
   input  logic [OPTN_NUM_RD_PORTS-1:0]                         i_ram_rd_en,
   input  logic [OPTN_NUM_RD_PORTS-1:0][RAM_IDX_WIDTH-1:0]      i_ram_rd_addr,
   output logic [OPTN_NUM_RD_PORTS-1:0]                         o_ram_rd_valid,
   output logic [OPTN_NUM_RD_PORTS-1:0][OPTN_DATA_WIDTH-1:0]    o_ram_rd_data,
   input  logic [OPTN_NUM_WR_PORTS-1:0]                         i_ram_wr_en,
   input  logic [OPTN_NUM_WR_PORTS-1:0][RAM_IDX_WIDTH-1:0]      i_ram_wr_addr,
   input  logic [OPTN_NUM_WR_PORTS-1:0][NUM_LANES-1:0]          i_ram_wr_byte_en,
   input  logic [OPTN_NUM_WR_PORTS-1:0][OPTN_DATA_WIDTH-1:0]    i_ram_wr_data
);

   localparam int BW = OPTN_BYTE_WIDTH;
   localparam logic [RAM_IDX_WIDTH:0]   DEPTH_EXT = (RAM_IDX_WIDTH+1)'(OPTN_RAM_DEPTH);
   localparam logic [RAM_IDX_WIDTH-1:0] LAST_IDX  = RAM_IDX_WIDTH'(OPTN_RAM_DEPTH - 1);

   ram_init_state_t             state, state_next;
   logic [RAM_IDX_WIDTH-1:0]    init_cnt;
   logic                        init_done;

   logic [OPTN_RAM_DEPTH-1:0][OPTN_DATA_WIDTH-1:0] mem;
   logic [OPTN_RAM_DEPTH-1:0][OPTN_DATA_WIDTH-1:0] wr_merged;
   logic [OPTN_RAM_DEPTH-1:0][NUM_LANES-1:0]       wr_lane_hit;

   // ---------------- clear FSM ----------------
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= RAM_INIT;
         init_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == RAM_INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RAM_INIT:  if (init_cnt == LAST_IDX) state_next = RAM_READY;
         RAM_READY: state_next = RAM_READY;
         default:   state_next = RAM_INIT;
      endcase
   end

   assign init_done       = (state == RAM_READY);
   assign o_ram_init_done = init_done;

   // ---------------- write path ----------------
   // Out-of-range addresses match no entry, so those writes drop naturally.
   for (genvar e = 0; e < OPTN_RAM_DEPTH; e++) begin : g_entry
      logic [OPTN_NUM_WR_PORTS-1:0] hit;
      always_comb begin
         hit = '0;
         for (int p = 0; p < OPTN_NUM_WR_PORTS; p++)
            hit[p] = init_done && i_ram_wr_en[p] && (i_ram_wr_addr[p] == RAM_IDX_WIDTH'(e));
      end
      procyon_ram_mp_wr_merge #(
         .NUM_WR     (OPTN_NUM_WR_PORTS),
         .NUM_LANES  (NUM_LANES),
         .BYTE_WIDTH (BW)
      ) u_merge (
         .hit      (hit),
         .byte_en  (i_ram_wr_byte_en),
         .data     (i_ram_wr_data),
         .merged   (wr_merged[e]),
         .lane_hit (wr_lane_hit[e])
      );
   end

   // Storage is not reset; the clear sequence zeroes it after reset.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         if (state == RAM_INIT) begin
            mem[init_cnt] <= '0;
         end else begin
            for (int e = 0; e < OPTN_RAM_DEPTH; e++)
               for (int l = 0; l < NUM_LANES; l++)
                  if (wr_lane_hit[e][l]) mem[e][l*BW +: BW] <= wr_merged[e][l*BW +: BW];
         end
      end
   end

   // ---------------- read path ----------------
   for (genvar r = 0; r < OPTN_NUM_RD_PORTS; r++) begin : g_rd
      logic                       in_range;
      logic                       valid;
      logic [OPTN_DATA_WIDTH-1:0] entry;
      logic [OPTN_DATA_WIDTH-1:0] rd_word;

      assign in_range = ({1'b0, i_ram_rd_addr[r]} < DEPTH_EXT);
      assign entry    = in_range ? mem[i_ram_rd_addr[r]] : '0;
      assign valid    = i_ram_rd_en[r] && init_done;

`ifdef PROCYON_RAM_MP_BYPASS_EN
      logic [OPTN_NUM_WR_PORTS-1:0] byp_hit;
      logic [OPTN_DATA_WIDTH-1:0]   byp_data;
      logic [NUM_LANES-1:0]         byp_lane;

      always_comb begin
         byp_hit = '0;
         for (int p = 0; p < OPTN_NUM_WR_PORTS; p++)
            byp_hit[p] = i_ram_wr_en[p] && (i_ram_wr_addr[p] == i_ram_rd_addr[r]);
      end

      procyon_ram_mp_wr_merge #(
         .NUM_WR     (OPTN_NUM_WR_PORTS),
         .NUM_LANES  (NUM_LANES),
         .BYTE_WIDTH (BW)
      ) u_byp (
         .hit      (byp_hit),
         .byte_en  (i_ram_wr_byte_en),
         .data     (i_ram_wr_data),
         .merged   (byp_data),
         .lane_hit (byp_lane)
      );

      // Out-of-range reads never see forwarded data: the write is dropped.
      always_comb begin
         rd_word = entry;
         if (in_range)
            for (int l = 0; l < NUM_LANES; l++)
               if (byp_lane[l]) rd_word[l*BW +: BW] = byp_data[l*BW +: BW];
      end
`else
      assign rd_word = entry;
`endif

      if (OPTN_RD_LATENCY == 0) begin : g_async
         assign o_ram_rd_valid[r] = valid;
         assign o_ram_rd_data[r]  = valid ? rd_word : '0;
      end else begin : g_sync
         logic                       valid_q;
         logic [OPTN_DATA_WIDTH-1:0] data_q;
         always_ff @(posedge clk) begin
            if (!n_rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else begin
               valid_q <= valid;
               data_q  <= valid ? rd_word : '0;
            end
         end
         assign o_ram_rd_valid[r] = valid_q;
         assign o_ram_rd_data[r]  = data_q;
      end
   end

endmodule
